cp_host_ctrl: RTL and testbench

Host-side job sequencer for one crypto processor (CP) instance, driving the CP's external loading, run-control and DMEM-readback interface. For each job it streams a program into IMEM and operands into DMEM, runs the CP to completion, and streams a result window of DMEM back to the host. It is the initiator for `cp_top`'s `ext_*` ports and sits between the host/bus adapter and `cp_top`.

---
 rtl/cp_host_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_cp_host_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_host_ctrl.sv
// cp_host_ctrl: host-side job sequencer for one CP instance (IMEM/DMEM load, run, DMEM readback).
// Defining CP_HOST_TIMEOUT_EN adds a RUN watchdog that aborts the job and raises err.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_I  | streaming program beats into IMEM
// LOAD_D  | streaming operand beats into DMEM from address 0
// RUN     | CP active, waiting for cp_ext_done (or watchdog expiry)
// RD_ADDR | readback address presented to DMEM port C
// RD_CAP  | DMEM read data captured into out_data
// RD_OUT  | out_valid held until out_ready
// FIN     | one-cycle done pulse
module cp_host_ctrl #(
    parameter int CP_D_WIDTH      = 72,
    parameter int CP_I_WIDTH      = 56,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int IMEM_ADDR_WIDTH = 9,
    parameter int TIMEOUT_WIDTH   = 20
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       start,
    input  logic [IMEM_ADDR_WIDTH:0]   prog_len,
    input  logic [DMEM_ADDR_WIDTH:0]   din_len,
    input  logic [DMEM_ADDR_WIDTH-1:0] dout_base,
    input  logic [DMEM_ADDR_WIDTH:0]   dout_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CP_D_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CP_D_WIDTH-1:0]      out_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       ext_cp_active,
    output logic [IMEM_ADDR_WIDTH-1:0] ext_imem_addr,
    output logic [CP_I_WIDTH-1:0]      ext_imem_in,
    output logic                       ext_imem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] ext_dmem_addr,
    output logic [CP_D_WIDTH-1:0]      ext_dmem_in,
    output logic                       ext_dmem_we,
    input  logic                       cp_ext_nbusy,
    input  logic                       cp_ext_done,
    input  logic [CP_D_WIDTH-1:0]      dmem_ext_out
);

    localparam int CW = ((DMEM_ADDR_WIDTH > IMEM_ADDR_WIDTH) ? DMEM_ADDR_WIDTH : IMEM_ADDR_WIDTH) + 1;
    localparam logic [IMEM_ADDR_WIDTH:0] IMEM_DEPTH = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};
    localparam logic [DMEM_ADDR_WIDTH:0] DMEM_DEPTH = {1'b1, {DMEM_ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_RD_ADDR,
        S_RD_CAP,
        S_RD_OUT,
        S_FIN
    } state_t;

    state_t                     state;
    logic [CW-1:0]              prog_len_q;
    logic [CW-1:0]              din_len_q;
    logic [CW-1:0]              dout_len_q;
    logic [DMEM_ADDR_WIDTH-1:0] dout_base_q;
    logic [CW-1:0]              cnt;
    logic [CW-1:0]              cnt_inc;
    logic [CW-1:0]              idx;
    logic [CW-1:0]              idx_inc;
    logic [IMEM_ADDR_WIDTH:0]   prog_sat;
    logic [DMEM_ADDR_WIDTH:0]   din_sat;
    logic [DMEM_ADDR_WIDTH:0]   dout_sat;
    logic [DMEM_ADDR_WIDTH-1:0] rd_addr;
    logic                       unused_nbusy;

`ifdef CP_HOST_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic                     err_q;
    assign err = err_q;
`else
    logic [TIMEOUT_WIDTH-1:0] unused_wd;
    assign unused_wd = '0;
    assign err       = 1'b0;
`endif

    // cp_ext_nbusy carries no control meaning here; the run ends on cp_ext_done alone.
    assign unused_nbusy = cp_ext_nbusy;

    assign prog_sat = (prog_len > IMEM_DEPTH) ? IMEM_DEPTH : prog_len;
    assign din_sat  = (din_len  > DMEM_DEPTH) ? DMEM_DEPTH : din_len;
    assign dout_sat = (dout_len > DMEM_DEPTH) ? DMEM_DEPTH : dout_len;

    assign cnt_inc = cnt + 1'b1;
    assign idx_inc = idx + 1'b1;
    assign rd_addr = dout_base_q + idx[DMEM_ADDR_WIDTH-1:0];

    assign in_ready      = (state == S_LOAD_I) || (state == S_LOAD_D);
    assign ext_imem_we   = (state == S_LOAD_I) && in_valid;
    assign ext_dmem_we   = (state == S_LOAD_D) && in_valid;
    assign ext_imem_addr = (state == S_LOAD_I) ? cnt[IMEM_ADDR_WIDTH-1:0] : '0;
    assign ext_imem_in   = (state == S_LOAD_I) ? in_data[CP_I_WIDTH-1:0] : '0;
    assign ext_dmem_in   = (state == S_LOAD_D) ? in_data : '0;

    // Readback address is held through RD_CAP/RD_OUT so the port sees a steady address.
    always_comb begin
        ext_dmem_addr = '0;
        if (state == S_LOAD_D)
            ext_dmem_addr = cnt[DMEM_ADDR_WIDTH-1:0];
        else if ((state == S_RD_ADDR) || (state == S_RD_CAP) || (state == S_RD_OUT))
            ext_dmem_addr = rd_addr;
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state         <= S_IDLE;
            prog_len_q    <= '0;
            din_len_q     <= '0;
            dout_len_q    <= '0;
            dout_base_q   <= '0;
            cnt           <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ext_cp_active <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
`ifdef CP_HOST_TIMEOUT_EN
            wd            <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        prog_len_q  <= CW'(prog_sat);
                        din_len_q   <= CW'(din_sat);
                        dout_len_q  <= CW'(dout_sat);
                        dout_base_q <= dout_base;
                        cnt         <= '0;
                        idx         <= '0;
                        busy        <= 1'b1;
`ifdef CP_HOST_TIMEOUT_EN
                        wd          <= '0;
                        err_q       <= 1'b0;
`endif
                        if (prog_sat != '0) begin
                            state <= S_LOAD_I;
                        end else if (din_sat != '0) begin
                            state <= S_LOAD_D;
                        end else begin
                            state         <= S_RUN;
                            ext_cp_active <= 1'b1;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (in_valid) begin
                        if (cnt_inc == prog_len_q) begin
                            cnt <= '0;
                            if (din_len_q != '0) begin
                                state <= S_LOAD_D;
                            end else begin
                                state         <= S_RUN;
                                ext_cp_active <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_LOAD_D: begin
                    if (in_valid) begin
                        if (cnt_inc == din_len_q) begin
                            cnt           <= '0;
                            state         <= S_RUN;
                            ext_cp_active <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                S_RUN: begin
                    if (cp_ext_done) begin
                        ext_cp_active <= 1'b0;
                        if (dout_len_q == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RD_ADDR;
                        end
                    end
`ifdef CP_HOST_TIMEOUT_EN
                    // Exit on the cycle the count would reach all-ones.
                    else if (wd == WD_LAST) begin
                        ext_cp_active <= 1'b0;
                        err_q         <= 1'b1;
                        state         <= S_FIN;
                        done          <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                S_RD_ADDR: begin
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    out_data  <= dmem_ext_out;
                    out_valid <= 1'b1;
                    state     <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx_inc == dout_len_q) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx_inc;
                            state <= S_RD_ADDR;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    ext_cp_active <= 1'b0;
                    out_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp_host_ctrl.sv
// tb_cp_host_ctrl: directed bench for cp_host_ctrl with simple IMEM/DMEM models and a CP done model.
// The timeout job runs only when CP_HOST_TIMEOUT_EN is defined (watchdog width 4).
module tb_cp_host_ctrl;

    localparam int TW = 4;

    logic        clk;
    logic        nreset;
    logic        start;
    logic [9:0]  prog_len;
    logic [10:0] din_len;
    logic [9:0]  dout_base;
    logic [10:0] dout_len;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        ext_cp_active;
    logic [8:0]  ext_imem_addr;
    logic [55:0] ext_imem_in;
    logic        ext_imem_we;
    logic [9:0]  ext_dmem_addr;
    logic [71:0] ext_dmem_in;
    logic        ext_dmem_we;
    logic        cp_ext_nbusy;
    logic        cp_ext_done;
    logic [71:0] dmem_ext_out;

    int n_cmp = 0;
    int n_mis = 0;

    int  act_tot  = 0;
    int  iwe_tot  = 0;
    int  dwe_tot  = 0;
    int  hs_tot   = 0;
    int  viol     = 0;
    bit  mem_init = 1'b0;

    logic [55:0] imem_m   [512];
    logic [71:0] dmem_m   [1024];
    logic [55:0] exp_imem [512];
    logic [71:0] exp_dmem [1024];

    cp_host_ctrl #(
        .CP_D_WIDTH      (72),
        .CP_I_WIDTH      (56),
        .DMEM_ADDR_WIDTH (10),
        .IMEM_ADDR_WIDTH (9),
        .TIMEOUT_WIDTH   (TW)
    ) dut (
        .clock         (clk),
        .nreset        (nreset),
        .start         (start),
        .prog_len      (prog_len),
        .din_len       (din_len),
        .dout_base     (dout_base),
        .dout_len      (dout_len),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .ext_cp_active (ext_cp_active),
        .ext_imem_addr (ext_imem_addr),
        .ext_imem_in   (ext_imem_in),
        .ext_imem_we   (ext_imem_we),
        .ext_dmem_addr (ext_dmem_addr),
        .ext_dmem_in   (ext_dmem_in),
        .ext_dmem_we   (ext_dmem_we),
        .cp_ext_nbusy  (cp_ext_nbusy),
        .cp_ext_done   (cp_ext_done),
        .dmem_ext_out  (dmem_ext_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] init_word(input int i);
        logic [31:0] a;
        a = i;
        return {8'h5A, 32'hC0DE_0000 + a, ~a};
    endfunction

    // Memory models for the CP side: write on we, DMEM port C with one cycle read latency.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) dmem_m[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            if (ext_imem_we) begin
                imem_m[ext_imem_addr] <= ext_imem_in;
                iwe_tot <= iwe_tot + 1;
            end
            if (ext_dmem_we) begin
                dmem_m[ext_dmem_addr] <= ext_dmem_in;
                dwe_tot <= dwe_tot + 1;
            end
        end
        dmem_ext_out <= dmem_m[ext_dmem_addr];
        if (ext_cp_active) act_tot <= act_tot + 1;
        if (out_valid && out_ready) hs_tot <= hs_tot + 1;
        if (ext_cp_active && (ext_imem_we || ext_dmem_we)) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic job(input int pl, input int dl, input int base, input int ol,
                       input int dly, input int stall, input bit gaps, input bit pulse_start);
        int ple, dle, ole, t, a0, i0, d0, h0, waddr, exp_act;
        logic [95:0] rnd;
        logic [71:0] d;
        logic [71:0] hold;
        ple = (pl > 512) ? 512 : pl;
        dle = (dl > 1024) ? 1024 : dl;
        ole = (ol > 1024) ? 1024 : ol;
        a0 = act_tot;
        i0 = iwe_tot;
        d0 = dwe_tot;
        h0 = hs_tot;
        prog_len  = 10'(pl);
        din_len   = 11'(dl);
        dout_base = 10'(base);
        dout_len  = 11'(ol);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", busy, 1);
        for (int b = 0; b < ple + dle; b++) begin
            if (gaps) begin
                in_valid = 1'b0;
                if (pulse_start && b == 1) begin
                    start    = 1'b1;
                    prog_len = 10'd7;
                end
                #1;
                chk("gap_no_we", {ext_imem_we, ext_dmem_we}, 0);
                @(negedge clk);
                start    = 1'b0;
                prog_len = 10'(pl);
            end
            rnd      = {$urandom(), $urandom(), $urandom()};
            d        = rnd[71:0];
            in_data  = d;
            in_valid = 1'b1;
            #1;
            chk("in_ready", in_ready, 1);
            if (b < ple) begin
                chk("imem_we", ext_imem_we, 1);
                chk("imem_addr", ext_imem_addr, b);
                chk("imem_in", ext_imem_in, d[55:0]);
                exp_imem[b] = d[55:0];
            end else begin
                chk("dmem_we", ext_dmem_we, 1);
                chk("dmem_addr", ext_dmem_addr, b - ple);
                chk("dmem_in", ext_dmem_in, d);
                exp_dmem[b - ple] = d;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("act_rise", ext_cp_active, 1);
        chk("in_ready_run", in_ready, 0);
        if (dly >= 0) begin
            for (int k = 0; k < dly; k++) @(negedge clk);
            cp_ext_done = 1'b1;
            @(negedge clk);
            cp_ext_done = 1'b0;
            chk("act_fall", ext_cp_active, 0);
            for (int w = 0; w < ole; w++) begin
                t = 0;
                while (!out_valid && t < 8) begin
                    @(negedge clk);
                    t++;
                end
                chk("ov_wait", out_valid, 1);
                chk("ov_latency", t, 2);
                waddr = (base + w) % 1024;
                for (int s = 0; s < stall; s++) begin
                    hold = out_data;
                    @(negedge clk);
                    chk("stall_hold", out_data, hold);
                    chk("stall_ov", out_valid, 1);
                end
                chk("rd_addr", ext_dmem_addr, waddr);
                chk("out_data", out_data, exp_dmem[waddr]);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
            exp_act = dly + 1;
        end else begin
            t = 0;
            while (!done && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("act_timeout_drop", ext_cp_active, 0);
            exp_act = 2 ** TW - 1;
        end
        chk("done", done, 1);
        chk("err", err, (dly < 0));
        chk("act_cycles", act_tot - a0, exp_act);
        chk("imem_writes", iwe_tot - i0, ple);
        chk("dmem_writes", dwe_tot - d0, dle);
        chk("handshakes", hs_tot - h0, (dly < 0) ? 0 : ole);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_end", busy, 0);
        for (int i = 0; i < ple; i++) chk("imem_model", imem_m[i], exp_imem[i]);
        for (int i = 0; i < dle; i++) chk("dmem_model", dmem_m[i], exp_dmem[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        nreset       = 1'b0;
        start        = 1'b0;
        prog_len     = '0;
        din_len      = '0;
        dout_base    = '0;
        dout_len     = '0;
        in_valid     = 1'b0;
        in_data      = 72'hFF_1234_5678_9ABC_DEF0;
        out_ready    = 1'b0;
        cp_ext_nbusy = 1'b1;
        cp_ext_done  = 1'b0;
        for (int i = 0; i < 1024; i++) exp_dmem[i] = init_word(i);
        for (int i = 0; i < 512; i++) exp_imem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_active", ext_cp_active, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_addr", ext_imem_addr, 0);
        chk("rst_imem_in", ext_imem_in, 0);
        chk("rst_dmem_addr", ext_dmem_addr, 0);
        chk("rst_dmem_in", ext_dmem_in, 0);
        chk("rst_we", {ext_imem_we, ext_dmem_we}, 0);
        nreset = 1'b1;
        @(negedge clk);

        // full job
        job(3, 2, 'h10, 2, 20, 0, 1'b0, 1'b0);
        // zero lengths
        job(0, 0, 0, 0, 3, 0, 1'b0, 1'b0);
        // address wrap with backpressure; DMEM[0] is freshly loaded
        job(0, 1, 'h3FF, 2, 5, 5, 1'b0, 1'b0);
        // input gaps with a start pulse during load
        job(4, 3, 'h2, 3, 7, 1, 1'b1, 1'b1);

        // reset while in RUN
        prog_len  = 10'd1;
        din_len   = 11'd0;
        dout_base = 10'd0;
        dout_len  = 11'd1;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_data  = 72'h0A_BBBB_CCCC_DDDD_EEEE;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid_pre_act", ext_cp_active, 1);
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        chk("rst_mid_act", ext_cp_active, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        nreset = 1'b1;
        @(negedge clk);
        job(2, 2, 0, 2, 10, 0, 1'b0, 1'b0);

        // length saturation: 600 -> 512 program beats, 1030 -> 1024 data beats
        job(600, 1030, 'h3FE, 3, 2, 0, 1'b0, 1'b0);

`ifdef CP_HOST_TIMEOUT_EN
        job(0, 0, 0, 1, -1, 0, 1'b0, 1'b0);
        job(0, 0, 0, 0, 2, 0, 1'b0, 1'b0);
`endif

        chk("we_while_active", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
